// File: rtl/lsu_dmem.sv
// -----------------------------------------------------------------------------
// lsu_dmem: load/store unit front end for a single-ported data memory.
//
// Accepts one core load/store at a time, checks it for legality, drives a
// word-aligned memory request with byte enables and lane-positioned write
// data, then returns the sign/zero-extended load result in a one-cycle
// response state.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   When defined, a watchdog aborts a BUSY access that has waited
//   TIMEOUT_CYCLES cycles without mem_ready_i and reports it as a fault.
//   When undefined, BUSY waits for mem_ready_i indefinitely.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   core_req_i        core requests an access (held while core_stall_o=1)
//   core_we_i         1 = store, 0 = load
//   core_size_i[2:0]  000 B, 001 H, 010 W, 100 BU, 101 HU
//   core_addr_i[31:0] byte address
//   core_wd_i[31:0]   right-aligned store data
//   core_rd_o[31:0]   registered, extended load result
//   core_stall_o      core must hold its request while 1
//   core_fault_o      access fault, only asserted in RESP
//   mem_req_o         memory request (BUSY only)
//   mem_we_o          memory write enable
//   mem_be_o[3:0]     byte enables (0000 for loads)
//   mem_addr_o[31:0]  word-aligned address
//   mem_wd_o[31:0]    lane-replicated write data
//   mem_rd_i[31:0]    memory read word
//   mem_ready_i       memory completes the current request this cycle
// -----------------------------------------------------------------------------
module lsu_dmem #(
    parameter int DMEM_BYTES     = 512,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic        fault_q;
    logic [31:0] rd_q;

    // ---------------------------------------------------------------
    // Legality of the incoming request (evaluated only in IDLE)
    // ---------------------------------------------------------------
    logic [2:0]  nbytes;
    logic [32:0] end_addr;   // one bit wider so addr+bytes cannot wrap
    logic        size_ok, align_ok, range_ok, req_legal;

    always_comb begin
        nbytes   = 3'd1;
        size_ok  = 1'b1;
        align_ok = 1'b1;
        case (core_size_i)
            3'b000, 3'b100: nbytes = 3'd1;
            3'b001, 3'b101: begin
                nbytes   = 3'd2;
                align_ok = ~core_addr_i[0];
            end
            3'b010: begin
                nbytes   = 3'd4;
                align_ok = (core_addr_i[1:0] == 2'b00);
            end
            default: size_ok = 1'b0;
        endcase
        // unsigned variants only make sense for loads
        if (core_we_i && core_size_i[2])
            size_ok = 1'b0;
        end_addr  = {1'b0, core_addr_i} + 33'(nbytes);
        range_ok  = (end_addr <= 33'(DMEM_BYTES));
        req_legal = size_ok & align_ok & range_ok;
    end

    // ---------------------------------------------------------------
    // Optional watchdog
    // ---------------------------------------------------------------
    logic timeout;
`ifdef LSU_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;

    // Fires on the BUSY cycle whose increment would reach the limit;
    // a ready on that same cycle wins.
    assign timeout = (state_q == BUSY) && !mem_ready_i &&
                     (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            wdog_q <= '0;
        else if (state_q != BUSY)
            wdog_q <= '0;
        else if (!mem_ready_i)
            wdog_q <= wdog_q + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Load lane extraction from the latched address/size
    // ---------------------------------------------------------------
    logic [31:0] lane_sh;
    logic [31:0] load_data;
    logic        sext;

    assign lane_sh = mem_rd_i >> {addr_q[1:0], 3'b000};
    assign sext    = ~size_q[2];

    always_comb begin
        case (size_q[1:0])
            2'b00:   load_data = {{24{sext & lane_sh[7]}},  lane_sh[7:0]};
            2'b01:   load_data = {{16{sext & lane_sh[15]}}, lane_sh[15:0]};
            default: load_data = mem_rd_i;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (core_req_i) state_d = req_legal ? BUSY : RESP;
            BUSY: if (mem_ready_i || timeout) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    logic [3:0] be_lane;

    always_comb begin
        case (size_q[1:0])
            2'b00:   be_lane = 4'b0001 << addr_q[1:0];
            2'b01:   be_lane = 4'b0011 << addr_q[1:0];
            default: be_lane = 4'b1111;
        endcase
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_be_o  = 4'b0000;
        if (state_q == BUSY) begin
            mem_req_o = 1'b1;
            mem_we_o  = we_q;
            mem_be_o  = we_q ? be_lane : 4'b0000;
        end
    end

    always_comb begin
        case (size_q[1:0])
            2'b00:   mem_wd_o = {4{wd_q[7:0]}};
            2'b01:   mem_wd_o = {2{wd_q[15:0]}};
            default: mem_wd_o = wd_q;
        endcase
    end

    assign mem_addr_o   = {addr_q[31:2], 2'b00};
    assign core_rd_o    = rd_q;
    assign core_fault_o = (state_q == RESP) && fault_q;
    assign core_stall_o = core_req_i && (state_q != RESP);

    // ---------------------------------------------------------------
    // Request latch, fault flag and load result
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= '0;
            wd_q    <= '0;
            fault_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (core_req_i) begin
                    we_q    <= core_we_i;
                    size_q  <= core_size_i;
                    addr_q  <= core_addr_i;
                    wd_q    <= core_wd_i;
                    fault_q <= ~req_legal;
                    // a rejected load returns zero; a rejected store leaves the result alone
                    if (!req_legal && !core_we_i)
                        rd_q <= '0;
                end
                BUSY: if (mem_ready_i) begin
                    fault_q <= 1'b0;
                    if (!we_q)
                        rd_q <= load_data;
                end else if (timeout) begin
                    fault_q <= 1'b1;
                    rd_q    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// -----------------------------------------------------------------------------
// tb_lsu_dmem: directed, table-driven bench for lsu_dmem.
// Each table row is one core access plus its hand-computed memory-side and
// core-side results; multi-cycle corners (reset in BUSY, watchdog) are
// written out as separate sequences.
// -----------------------------------------------------------------------------
module tb_lsu_dmem;

    logic        clk;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int total = 0;
    int bad   = 0;

    lsu_dmem #(.DMEM_BYTES(512), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_fault_o(core_fault_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past 200us");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;      // BUSY cycles without ready before ready
        logic        exp_fault;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_maddr;
        int          exp_stalls;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stalls = 0;
        int busy = 0;
        bit done = 0, mem_bad = 0, early_fault = 0, saw_req = 0;
        @(negedge clk);
        core_req_i  = 1'b1;
        core_we_i   = v.we;
        core_size_i = v.size;
        core_addr_i = v.addr;
        core_wd_i   = v.wd;
        mem_rd_i    = v.rdata;
        mem_ready_i = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            if (!core_stall_o) begin
                done = 1;
                break;
            end
            stalls++;
            if (core_fault_o) early_fault = 1;
            if (mem_req_o) begin
                saw_req = 1;
                busy++;
                if (mem_be_o !== v.exp_be || mem_wd_o !== v.exp_wd ||
                    mem_addr_o !== v.exp_maddr || mem_we_o !== v.we)
                    mem_bad = 1;
                mem_ready_i = (busy > v.delay);
                // core fields change under a busy access; they must be ignored
                core_addr_i = ~v.addr;
                core_wd_i   = ~v.wd;
                core_size_i = 3'b011;
                core_we_i   = ~v.we;
            end
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL v%0d no_release: stall still high after 64 cycles", idx);
        end else begin
            chk($sformatf("v%0d stalls", idx), 32'(stalls), 32'(v.exp_stalls));
            chk($sformatf("v%0d fault", idx), 32'(core_fault_o), 32'(v.exp_fault));
            chk($sformatf("v%0d rd", idx), core_rd_o, v.exp_rd);
            chk($sformatf("v%0d early_fault", idx), 32'(early_fault), 32'd0);
            chk($sformatf("v%0d resp_mem_idle", idx), {mem_req_o, mem_we_o, mem_be_o}, 32'd0);
            if (v.exp_fault)
                chk($sformatf("v%0d no_mem_req", idx), 32'(saw_req), 32'd0);
            else
                chk($sformatf("v%0d mem_fields", idx), 32'(mem_bad), 32'd0);
        end
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    initial begin
        //               we    size    addr      wd            rdata         dly flt exp_rd        be       exp_wd        maddr    stl
        vecs[0]  = '{1'b0, 3'b000, 32'h013, 32'h0,        32'h80000000, 0, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0,        32'h010, 2};
        vecs[1]  = '{1'b1, 3'b001, 32'h006, 32'h0000BEEF, 32'h0,        0, 1'b0, 32'hFFFFFF80, 4'b1100, 32'hBEEFBEEF, 32'h004, 2};
        vecs[2]  = '{1'b0, 3'b010, 32'h002, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vecs[3]  = '{1'b0, 3'b100, 32'h003, 32'h0,        32'hAB000000, 2, 1'b0, 32'h000000AB, 4'b0000, 32'h0,        32'h000, 4};
        vecs[4]  = '{1'b0, 3'b010, 32'h200, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vecs[5]  = '{1'b0, 3'b101, 32'h1FE, 32'h0,        32'hF00D1234, 3, 1'b0, 32'h0000F00D, 4'b0000, 32'h0,        32'h1FC, 5};
        vecs[6]  = '{1'b1, 3'b000, 32'h001, 32'h12345678, 32'h0,        0, 1'b0, 32'h0000F00D, 4'b0010, 32'h78787878, 32'h000, 2};
        vecs[7]  = '{1'b1, 3'b010, 32'h1FC, 32'hDEADBEEF, 32'h0,        1, 1'b0, 32'h0000F00D, 4'b1111, 32'hDEADBEEF, 32'h1FC, 3};
        vecs[8]  = '{1'b0, 3'b001, 32'h002, 32'h0,        32'h80010000, 0, 1'b0, 32'hFFFF8001, 4'b0000, 32'h0,        32'h000, 2};
        vecs[9]  = '{1'b1, 3'b100, 32'h004, 32'h00000055, 32'h0,        0, 1'b1, 32'hFFFF8001, 4'b0000, 32'h0,        32'h0,   1};
        vecs[10] = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vecs[11] = '{1'b0, 3'b010, 32'h008, 32'h0,        32'h13579BDF, 1, 1'b0, 32'h13579BDF, 4'b0000, 32'h0,        32'h008, 3};
        vecs[12] = '{1'b0, 3'b001, 32'h001, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vecs[13] = '{1'b1, 3'b000, 32'h200, 32'h000000AA, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,   1};
        vecs[14] = '{1'b0, 3'b000, 32'h1FF, 32'h0,        32'h7F000000, 0, 1'b0, 32'h0000007F, 4'b0000, 32'h0,        32'h1FC, 2};

        rst_ni      = 1'b0;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'b000;
        core_addr_i = '0;
        core_wd_i   = '0;
        mem_rd_i    = '0;
        mem_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst rd", core_rd_o, 32'd0);
        chk("rst fault", 32'(core_fault_o), 32'd0);
        chk("rst mem_ctl", {mem_req_o, mem_we_o, mem_be_o}, 32'd0);
        chk("rst mem_addr", mem_addr_o, 32'd0);
        chk("rst mem_wd", mem_wd_o, 32'd0);
        chk("rst stall", 32'(core_stall_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 15; i++)
            run_vec(vecs[i], i);

        // reset in the middle of a BUSY access (result register holds 0x7F here)
        begin
            bit leak = 0;
            @(negedge clk);
            core_req_i  = 1'b1;
            core_we_i   = 1'b0;
            core_size_i = 3'b010;
            core_addr_i = 32'h10;
            core_wd_i   = 32'h0;
            mem_ready_i = 1'b0;
            @(negedge clk);
            #1;
            chk("rstbusy in_busy", 32'(mem_req_o), 32'd1);
            #2;
            rst_ni = 1'b0;
            #1;
            chk("rstbusy mem_req", 32'(mem_req_o), 32'd0);
            chk("rstbusy rd", core_rd_o, 32'd0);
            chk("rstbusy fault", 32'(core_fault_o), 32'd0);
            chk("rstbusy mem_addr", mem_addr_o, 32'd0);
            core_req_i = 1'b0;
            @(negedge clk);
            rst_ni = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1;
                if (mem_req_o || core_fault_o) leak = 1;
            end
            chk("rstbusy no_response", 32'(leak), 32'd0);
            run_vec(vecs[0], 100);
        end

        // watchdog: ready never arrives (result register holds 0xFFFFFF80 here)
        begin
            int stalls = 0;
            int busy = 0;
            bit released = 0;
            @(negedge clk);
            core_req_i  = 1'b1;
            core_we_i   = 1'b0;
            core_size_i = 3'b010;
            core_addr_i = 32'h20;
            mem_ready_i = 1'b0;
            for (int cyc = 0; cyc < 120; cyc++) begin
                #1;
                if (!core_stall_o) begin
                    released = 1;
                    break;
                end
                stalls++;
                if (mem_req_o) busy++;
                @(negedge clk);
            end
`ifdef LSU_TIMEOUT_EN
            chk("wdog released", 32'(released), 32'd1);
            chk("wdog busy_cycles", 32'(busy), 32'd16);
            chk("wdog stalls", 32'(stalls), 32'd17);
            chk("wdog fault", 32'(core_fault_o), 32'd1);
            chk("wdog rd", core_rd_o, 32'd0);
            core_req_i = 1'b0;
            @(negedge clk);
            #1;
            chk("wdog idle_fault", 32'(core_fault_o), 32'd0);
`else
            chk("nowdog released", 32'(released), 32'd0);
            chk("nowdog busy_cycles", 32'(busy), 32'd119);
            chk("nowdog mem_req", 32'(mem_req_o), 32'd1);
            chk("nowdog rd_held", core_rd_o, 32'hFFFFFF80);
            rst_ni = 1'b0;
            #1;
            core_req_i = 1'b0;
            @(negedge clk);
            rst_ni = 1'b1;
`endif
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
